// File: rtl/imm_pkg.sv
// Shared types and constants for the pipelined immediate generator.
// Contents: format codes, RV32I/RV64I major opcodes, and the buffered entry payload.
package imm_pkg;

    localparam int unsigned INSTR_W   = 32;
    localparam int unsigned IMM_MAX_W = 64;
    localparam int unsigned TAG_MAX_W = 64;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6
    } fmt_e;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Sized for the widest legal XLEN/TAG_W; narrower instances zero-fill the top.
    typedef struct packed {
        logic [IMM_MAX_W-1:0] imm;
        fmt_e                 fmt;
        logic                 illegal;
        logic [TAG_MAX_W-1:0] tag;
    } imm_entry_t;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: instruction word -> {imm, fmt, illegal}.
// Ports: instr (32b raw word), imm (XLEN, sign/zero extended), fmt (fmt_e),
//        illegal (low two bits not 2'b11).
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [INSTR_W-1:0] instr,
    output logic [XLEN-1:0]    imm,
    output fmt_e               fmt,
    output logic               illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_decode: XLEN must be 32 or 64");
    end

    // Raw immediates as signed fields so a width cast performs the sign extension.
    logic signed [11:0] imm_i;
    logic signed [11:0] imm_s;
    logic signed [12:0] imm_b;
    logic signed [31:0] imm_u;
    logic signed [20:0] imm_j;

    assign imm_i = instr[31:20];
    assign imm_s = {instr[31:25], instr[11:7]};
    assign imm_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    assign illegal = (instr[1:0] != 2'b11);

    // Format select by major opcode.
    always_comb begin
        imm = '0;
        fmt = FMT_NONE;
        case (instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE: begin
                imm = XLEN'(imm_i);
                fmt = FMT_I;
            end
            OP_IMM32: begin
                if (XLEN == 64) begin
                    imm = XLEN'(imm_i);
                    fmt = FMT_I;
                end
            end
            OP_STORE: begin
                imm = XLEN'(imm_s);
                fmt = FMT_S;
            end
            OP_BRANCH: begin
                imm = XLEN'(imm_b);
                fmt = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                imm = XLEN'(imm_u);
                fmt = FMT_U;
            end
            OP_JAL: begin
                imm = XLEN'(imm_j);
                fmt = FMT_J;
            end
            OP_SYSTEM: begin
                // Only the CSR*I variants carry a (zero-extended) immediate.
                if (instr[14]) begin
                    imm = XLEN'(instr[19:15]);
                    fmt = FMT_Z;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator with a 2-entry skid buffer and synchronous flush.
// Ports: clk, rst (sync, active-high), flush (sync drop of all entries),
//        in_valid/in_ready/in_instr/in_tag (upstream), out_valid/out_ready/
//        out_imm/out_fmt/out_illegal/out_tag (downstream, registered).
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_imm,
    output logic [2:0]         out_fmt,
    output logic               out_illegal,
    output logic [TAG_W-1:0]   out_tag
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
    if (TAG_W == 0 || TAG_W > TAG_MAX_W) begin : g_bad_tag
        $error("imm_gen_pipe: TAG_W must be 1..64");
    end

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .instr   (in_instr),
        .imm     (dec_imm),
        .fmt     (dec_fmt),
        .illegal (dec_illegal)
    );

    imm_entry_t new_entry;
    imm_entry_t main_q, main_d;
    imm_entry_t skid_q, skid_d;
    logic       main_valid, main_valid_d;
    logic       skid_valid, skid_valid_d;
    logic       accept;
    logic       emit;

    // Pack the decoded instruction into a buffer entry.
    always_comb begin
        new_entry         = '0;
        new_entry.imm     = IMM_MAX_W'(dec_imm);
        new_entry.fmt     = dec_fmt;
        new_entry.illegal = dec_illegal;
        new_entry.tag     = TAG_MAX_W'(in_tag);
    end

    assign in_ready = !rst && !skid_valid;
    assign accept   = in_valid && in_ready;
    assign emit     = main_valid && out_ready;

    // Skid-buffer next state; main is the head, skid only fills while main stalls.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        main_valid_d = main_valid;
        skid_valid_d = skid_valid;
        if (flush) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (emit) begin
            if (skid_valid) begin
                // in_ready is low whenever skid is full, so no accept can collide here.
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else if (accept) begin
                main_d = new_entry;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (!main_valid) begin
            if (accept) begin
                main_d       = new_entry;
                main_valid_d = 1'b1;
            end
        end else if (accept) begin
            skid_d       = new_entry;
            skid_valid_d = 1'b1;
        end
    end

    // State registers; reset clears data too so out_* read zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_valid <= main_valid_d;
            skid_valid <= skid_valid_d;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm[XLEN-1:0];
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag[TAG_W-1:0];

    // Bits above XLEN/TAG_W are always zero and intentionally not presented.
    logic unused_hi;
    assign unused_hi = ^{main_q.imm, main_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_tag;
    logic        out_ready;

    logic        in_ready32, out_valid32, out_ill32;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt32;
    logic [31:0] out_tag32;
    logic        in_ready64, out_valid64, out_ill64;
    logic [63:0] out_imm64;
    logic [2:0]  out_fmt64;
    logic [31:0] out_tag64;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_ill32), .out_tag(out_tag32)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
        .out_fmt(out_fmt64), .out_illegal(out_ill64), .out_tag(out_tag64)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] e32;
        logic [63:0] e64;
        logic [2:0]  f32;
        logic [2:0]  f64;
        logic        ill;
        logic [31:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails = 0;
    int   timeouts = 0;
    bit   done = 0;
    bit   started = 0;
    bit   rst_seen = 0;
    bit   stall_prev = 0;
    logic [31:0] s_imm32, s_tag32;
    logic [63:0] s_imm64;
    logic [2:0]  s_fmt32;
    logic        s_ill32;

    // Reference decode from the ISA field definitions, using signed arithmetic.
    function automatic void ref_decode(input logic [31:0] ins, input int xlen,
                                       output logic [63:0] imm, output logic [2:0] fmt);
        longint s;
        longint v;
        s   = $signed(ins);
        v   = 0;
        fmt = 3'd0;
        case (ins[6:0])
            7'h13, 7'h03, 7'h67, 7'h0F: begin v = s >>> 20; fmt = 3'd1; end
            7'h1B: if (xlen == 64) begin v = s >>> 20; fmt = 3'd1; end
            7'h23: begin v = ((s >>> 25) <<< 5) | longint'(ins[11:7]); fmt = 3'd2; end
            7'h63: begin
                v = ((s >>> 31) <<< 12) | (longint'(ins[7]) << 11)
                  | (longint'(ins[30:25]) << 5) | (longint'(ins[11:8]) << 1);
                fmt = 3'd3;
            end
            7'h37, 7'h17: begin v = (s >>> 12) <<< 12; fmt = 3'd4; end
            7'h6F: begin
                v = ((s >>> 31) <<< 20) | (longint'(ins[19:12]) << 12)
                  | (longint'(ins[20]) << 11) | (longint'(ins[30:21]) << 1);
                fmt = 3'd5;
            end
            7'h73: if (ins[14]) begin v = longint'(ins[19:15]); fmt = 3'd6; end
            default: ;
        endcase
        imm = (xlen == 32) ? (64'(v) & 64'h0000_0000_FFFF_FFFF) : 64'(v);
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: samples at negedge, i.e. the values the next rising edge will see.
    always @(negedge clk) begin
        int   sz;
        exp_t e;
        exp_t h;
        sz = q.size();
        if (done) begin
            chk("drain_empty", 64'(sz), 64'd0);
            chk("stim_timeouts", 64'(timeouts), 64'd0);
            $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
            $finish;
        end
        if (rst_seen) begin
            chk("rst_out_valid32", 64'(out_valid32), 64'd0);
            chk("rst_out_valid64", 64'(out_valid64), 64'd0);
            chk("rst_imm32", 64'(out_imm32), 64'd0);
            chk("rst_imm64", out_imm64, 64'd0);
            chk("rst_fmt", 64'({out_fmt32, out_fmt64}), 64'd0);
            chk("rst_tag", 64'({out_tag32, out_tag64}), 64'd0);
            chk("rst_ill", 64'({out_ill32, out_ill64}), 64'd0);
        end
        if (started) begin
            chk("in_ready32", 64'(in_ready32), 64'(!rst && sz < 2));
            chk("in_ready64", 64'(in_ready64), 64'(!rst && sz < 2));
            chk("out_valid32", 64'(out_valid32), 64'(sz != 0));
            chk("out_valid64", 64'(out_valid64), 64'(sz != 0));
        end
        if (stall_prev) begin
            chk("hold_imm32", 64'(out_imm32), 64'(s_imm32));
            chk("hold_imm64", out_imm64, s_imm64);
            chk("hold_misc", 64'({out_fmt32, out_ill32, out_tag32}), 64'({s_fmt32, s_ill32, s_tag32}));
        end
        if (started && !rst && sz > 0 && out_ready) begin
            h = q.pop_front();
            chk("imm32", 64'(out_imm32), h.e32);
            chk("imm64", out_imm64, h.e64);
            chk("fmt32", 64'(out_fmt32), 64'(h.f32));
            chk("fmt64", 64'(out_fmt64), 64'(h.f64));
            chk("illegal", 64'({out_ill32, out_ill64}), 64'({h.ill, h.ill}));
            chk("tag32", 64'(out_tag32), 64'(h.tag));
            chk("tag64", 64'(out_tag64), 64'(h.tag));
        end
        if (rst || flush) begin
            q.delete();
        end else if (started && in_valid && sz < 2) begin
            ref_decode(in_instr, 32, e.e32, e.f32);
            ref_decode(in_instr, 64, e.e64, e.f64);
            e.ill = (in_instr[1:0] != 2'b11);
            e.tag = in_tag;
            q.push_back(e);
        end
        stall_prev = started && !rst && !flush && sz > 0 && !out_ready;
        s_imm32 = out_imm32;
        s_imm64 = out_imm64;
        s_fmt32 = out_fmt32;
        s_ill32 = out_ill32;
        s_tag32 = out_tag32;
        rst_seen = rst;
        if (rst) started = 1;
    end

    int tag_ctr = 32'h100;

    task automatic send(input logic [31:0] instr);
        bit acc;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = 32'(tag_ctr);
        tag_ctr++;
        for (int n = 0; n < 100; n++) begin
            acc = in_ready32;
            @(posedge clk); #1;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        timeouts++;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [14];
        ops = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B, 7'h23, 7'h63,
                7'h37, 7'h17, 7'h6F, 7'h73, 7'h33, 7'h01, 7'h7F};
        w = $urandom;
        w[6:0] = ops[$urandom_range(0, 13)];
        return w;
    endfunction

    logic [31:0] directed [12];

    initial begin
        directed = '{32'hFFF00093, 32'hFE000EE3, 32'h0080006F, 32'h00112423,
                     32'h123452B7, 32'h80000037, 32'h3401D073, 32'h00000033,
                     32'h00000001, 32'hFFF0809B, 32'h34011073, 32'h800000EF};
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        in_valid = 1'b1; in_instr = 32'hFFF00093; in_tag = 32'hDEAD;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        cycles(2);

        // Each format, one at a time, full-rate downstream.
        foreach (directed[i]) send(directed[i]);
        cycles(2);

        // Backpressure: A to main, B to skid, C stalls until out_ready rises.
        out_ready = 1'b0;
        fork
            begin send(32'hFFF00093); send(32'h00112423); send(32'h0080006F); end
            begin cycles(5); out_ready = 1'b1; end
        join
        cycles(3);

        // Flush with both entries full and a new input offered.
        out_ready = 1'b0;
        send(32'h123452B7); send(32'hFE000EE3);
        in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 32'hBAD0; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycles(3);

        // Flush while an input is actually accepted: it must be discarded.
        out_ready = 1'b0;
        send(32'h3401D073);
        in_valid = 1'b1; in_instr = 32'h00700093; in_tag = 32'hBAD1; flush = 1'b1;
        cycles(1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cycles(3);

        // Reset mid-operation, then normal traffic resumes.
        out_ready = 1'b0;
        send(32'h80000037); send(32'hFFF00093);
        rst = 1'b1;
        cycles(1);
        rst = 1'b0; out_ready = 1'b1;
        send(32'hFE000EE3);
        cycles(3);

        // Randomized traffic with occasional flush and reset.
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_instr  = rand_instr();
            in_tag    = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 149) == 0);
            @(posedge clk); #1;
        end

        in_valid = 1'b0; flush = 1'b0; rst = 1'b0; out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            if (q.size() == 0) break;
            @(posedge clk); #1;
        end
        done = 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
